// File: rtl/utopia_pkg.sv
// Shared constants and types for the UTOPIA Level 1 PHY-side cell source.
// Host cells carry 52 bytes; the HEC is inserted at byte 4 on the UTOPIA side.
package utopia_pkg;

    localparam int CELL_BYTES = 53;
    localparam int HOST_BYTES = 52;
    localparam int HDR_BYTES  = 4;
    localparam int HEC_IDX    = 4;
    localparam logic [7:0] HEC_COSET = 8'h55;

    typedef enum logic {SRC_IDLE, SRC_PRESENT} src_state_e;

endpackage

// File: rtl/hec_crc8.sv
// Byte-serial CRC-8 (x^8+x^2+x+1, MSB first, init 0) used to build the ATM HEC.
// crc_next is the value including the current data byte, so a caller can capture it on the final byte.
module hec_crc8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [7:0] acc;
    logic       fb;

    always_comb begin
        acc = clr ? 8'h00 : crc_q;
        fb  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb  = acc[7] ^ data[i];
            acc = {acc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        crc_next = acc;
        if (en) begin
            crc_d = acc;
        end else if (clr) begin
            crc_d = 8'h00;
        end else begin
            crc_d = crc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/utopia_phy_cell_source.sv
// UTOPIA Level 1 Rx PHY cell source: buffers host cells, inserts HEC, and presents
// 53-byte cells to the ATM layer under the rx_clav / rx_en_n cell-level handshake.
module utopia_phy_cell_source
    import utopia_pkg::*;
#(
    parameter int NUM_CELLS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    input  logic                           in_sop,
    output logic                           in_ready,
    output logic                           in_err,
    output logic [7:0]                     rx_data,
    output logic                           rx_soc,
    output logic                           rx_clav,
    input  logic                           rx_en_n,
    output logic [$clog2(NUM_CELLS+1)-1:0] cell_count
);

    localparam int PW = $clog2(NUM_CELLS);
    localparam int CW = $clog2(NUM_CELLS + 1);
    localparam logic [5:0]    WR_LAST  = 6'(HOST_BYTES - 1);
    localparam logic [5:0]    RD_LAST  = 6'(CELL_BYTES - 1);
    localparam logic [5:0]    HDR_N    = 6'(HDR_BYTES);
    localparam logic [5:0]    HDR_LAST = 6'(HDR_BYTES - 1);
    localparam logic [5:0]    HEC_POS  = 6'(HEC_IDX);
    localparam logic [CW-1:0] FULL     = CW'(NUM_CELLS);

    logic [7:0] cell_mem [NUM_CELLS][HOST_BYTES];
    logic [7:0] hec_mem  [NUM_CELLS];

    src_state_e    state_q, state_d;
    logic [5:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_soc_q, rx_soc_d, clav_q, clav_d, err_q, err_d;

    logic          wr_fire, mem_we, hec_we, commit, free, avail;
    logic          crc_clr, crc_en, load, blank;
    logic [5:0]    mem_waddr, sel_idx;
    logic [PW-1:0] sel_ptr;
    logic [7:0]    sel_byte, crc_next;

    assign in_ready   = (count_q < FULL) & ~rst;
    assign wr_fire    = in_valid & in_ready;
    assign in_err     = err_q;
    assign rx_data    = rx_data_q;
    assign rx_soc     = rx_soc_q;
    assign rx_clav    = clav_q;
    assign cell_count = count_q;

    hec_crc8 u_hec (
        .clk      (clk),
        .rst      (rst),
        .clr      (crc_clr),
        .en       (crc_en),
        .data     (in_data),
        .crc_next (crc_next)
    );

    // Write side: an in_sop byte always (re)starts a cell, discarding any partial one.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_ptr_d  = wr_ptr_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_idx_q;
        hec_we    = 1'b0;
        commit    = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        if (wr_fire) begin
            if (in_sop) begin
                err_d     = (wr_idx_q != 6'd0);
                mem_we    = 1'b1;
                mem_waddr = 6'd0;
                wr_idx_d  = 6'd1;
                crc_clr   = 1'b1;
                crc_en    = 1'b1;
            end else if (wr_idx_q == 6'd0) begin
                err_d = 1'b1;
            end else begin
                mem_we = 1'b1;
                crc_en = (wr_idx_q < HDR_N);
                hec_we = (wr_idx_q == HDR_LAST);
                if (wr_idx_q == WR_LAST) begin
                    commit   = 1'b1;
                    wr_idx_d = 6'd0;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    wr_idx_d = wr_idx_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            cell_mem[wr_ptr_q][mem_waddr] <= in_data;
        end
        if (hec_we) begin
            hec_mem[wr_ptr_q] <= crc_next ^ HEC_COSET;
        end
    end

    // Occupancy after this edge drives both clav and the read FSM, so a freshly
    // committed cell is presented in the very next cycle.
    always_comb begin
        free = (state_q == SRC_PRESENT) && !rx_en_n && (rd_idx_q == RD_LAST);
        case ({commit, free})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        avail  = (count_d != '0);
        clav_d = avail;
    end

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        rd_ptr_d = rd_ptr_q;
        load     = 1'b0;
        blank    = 1'b0;
        sel_ptr  = rd_ptr_q;
        sel_idx  = 6'd0;
        case (state_q)
            SRC_IDLE: begin
                blank = 1'b1;
                if (avail) begin
                    state_d  = SRC_PRESENT;
                    rd_idx_d = 6'd0;
                    load     = 1'b1;
                end
            end
            SRC_PRESENT: begin
                if (!rx_en_n) begin
                    if (rd_idx_q == RD_LAST) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        rd_idx_d = 6'd0;
                        if (avail) begin
                            load    = 1'b1;
                            sel_ptr = rd_ptr_q + 1'b1;
                        end else begin
                            state_d = SRC_IDLE;
                            blank   = 1'b1;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + 6'd1;
                        sel_idx  = rd_idx_q + 6'd1;
                        load     = 1'b1;
                    end
                end
            end
            default: state_d = SRC_IDLE;
        endcase
    end

    // UTOPIA byte k maps to host byte k for the header, the HEC at 4, host byte k-1 after.
    always_comb begin
        if (sel_idx < HDR_N) begin
            sel_byte = cell_mem[sel_ptr][sel_idx];
        end else if (sel_idx == HEC_POS) begin
            sel_byte = hec_mem[sel_ptr];
        end else begin
            sel_byte = cell_mem[sel_ptr][sel_idx - 6'd1];
        end
        rx_data_d = rx_data_q;
        rx_soc_d  = rx_soc_q;
        if (load) begin
            rx_data_d = sel_byte;
            rx_soc_d  = (sel_idx == 6'd0);
        end else if (blank) begin
            rx_data_d = 8'h00;
            rx_soc_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SRC_IDLE;
            wr_idx_q  <= 6'd0;
            rd_idx_q  <= 6'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rx_data_q <= 8'h00;
            rx_soc_q  <= 1'b0;
            clav_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rx_data_q <= rx_data_d;
            rx_soc_q  <= rx_soc_d;
            clav_q    <= clav_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_utopia_phy_cell_source.sv
// Bench for utopia_phy_cell_source: host-side driver feeds a cell-level reference model
// whose expected UTOPIA bytes are queued and compared by a negedge monitor.
module tb_utopia_phy_cell_source;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic       in_ready, in_err;
    logic [7:0] rx_data;
    logic       rx_soc, rx_clav;
    logic       rx_en_n = 1'b1;
    logic [2:0] cell_count;

    utopia_phy_cell_source #(.NUM_CELLS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_ready   (in_ready),
        .in_err     (in_err),
        .rx_data    (rx_data),
        .rx_soc     (rx_soc),
        .rx_clav    (rx_clav),
        .rx_en_n    (rx_en_n),
        .cell_count (cell_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];
    logic [7:0] cur_q[$];
    int n_commit = 0;
    int n_free = 0;
    int mon_k = 0;
    int mode = 1;
    int pause_n = 0;
    logic prev_hold = 1'b0;
    logic [8:0] prev_val = 9'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // HEC as the remainder of hdr*x^8 divided by x^8+x^2+x+1, then the coset.
    function automatic logic [7:0] ref_hec(input logic [31:0] hdr);
        logic [39:0] v;
        v = {hdr, 8'h00};
        for (int i = 39; i >= 8; i--) begin
            if (v[i]) v = v ^ (40'h107 << (i - 8));
        end
        return v[7:0] ^ 8'h55;
    endfunction

    // Host-side rules: returns whether this byte must raise in_err.
    function automatic logic model_byte(input logic [7:0] b, input logic sop);
        logic e;
        logic [7:0] h;
        e = 1'b0;
        if (sop) begin
            e = (cur_q.size() != 0);
            cur_q.delete();
            cur_q.push_back(b);
        end else if (cur_q.size() == 0) begin
            e = 1'b1;
        end else begin
            cur_q.push_back(b);
            if (cur_q.size() == 52) begin
                h = ref_hec({cur_q[0], cur_q[1], cur_q[2], cur_q[3]});
                for (int k = 0; k < 53; k++) begin
                    if (k < 4)       exp_q.push_back({k == 0, cur_q[k]});
                    else if (k == 4) exp_q.push_back({1'b0, h});
                    else             exp_q.push_back({1'b0, cur_q[k-1]});
                end
                n_commit++;
                cur_q.delete();
            end
        end
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic sop);
        logic ok;
        logic e;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data = b;
        in_sop = sop;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) begin
            check("in_ready_timeout", 32'(ok), 32'd1);
        end else begin
            e = model_byte(b, sop);
            check("in_err", 32'(in_err), 32'(e));
        end
    endtask

    task automatic send_cell(input logic [31:0] hdr, input logic [7:0] p0, input logic rnd);
        for (int k = 0; k < 52; k++) begin
            if (k < 4)    send_byte(hdr[31-8*k -: 8], k == 0);
            else if (rnd) send_byte(8'($urandom), 1'b0);
            else          send_byte(p0 + 8'(k - 4), 1'b0);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 5000; t++) begin
            if (exp_q.size() == 0 && n_commit == n_free) break;
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        cur_q.delete();
        n_commit = 0;
        n_free = 0;
        mon_k = 0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rx_clav", 32'(rx_clav), 32'd0);
        check("rst_rx_soc", 32'(rx_soc), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_cell_count", 32'(cell_count), 32'd0);
        check("rst_in_err", 32'(in_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // ATM-layer enable pattern: 0 always read, 1 hold off, 2 random, 3 pause 3 cycles at byte 10.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (mode)
                0: rx_en_n = 1'b0;
                1: rx_en_n = 1'b1;
                2: rx_en_n = ($urandom_range(0, 2) == 0);
                default: begin
                    if (mon_k == 10 && pause_n < 3) begin
                        rx_en_n = 1'b1;
                        pause_n++;
                    end else begin
                        rx_en_n = 1'b0;
                        if (mon_k != 10) pause_n = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            check("cell_count", 32'(cell_count), 32'(n_commit - n_free));
            check("in_ready", 32'(in_ready), 32'((n_commit - n_free) < 4));
            check("rx_clav", 32'(rx_clav), 32'((n_commit - n_free) > 0));
            if (prev_hold && rx_clav) check("hold", 32'({rx_soc, rx_data}), 32'(prev_val));
            prev_hold = 1'b0;
            if (rx_clav && !rx_en_n) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_byte: got %0h expected no byte at %0t", {rx_soc, rx_data}, $time);
                end else begin
                    check("rx_byte", 32'({rx_soc, rx_data}), 32'(exp_q.pop_front()));
                    mon_k++;
                    if (mon_k == 53) begin
                        mon_k = 0;
                        n_free++;
                    end
                end
            end else if (rx_clav) begin
                prev_hold = 1'b1;
                prev_val = {rx_soc, rx_data};
            end else begin
                check("idle_out", 32'({rx_soc, rx_data}), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        mode = 0;
        send_cell(32'h0000_0000, 8'h00, 1'b0);
        drain();
        send_cell(32'h0000_0001, 8'h10, 1'b0);
        send_cell(32'h0102_0304, 8'h40, 1'b0);
        drain();

        mode = 1;
        for (int c = 0; c < 4; c++) send_cell(32'($urandom), 8'h00, 1'b1);
        @(negedge clk);
        check("full_count", 32'(cell_count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        mode = 0;
        send_cell(32'hA5A5_0F0F, 8'h80, 1'b0);
        drain();

        mode = 3;
        send_cell(32'h1122_3344, 8'h20, 1'b0);
        send_cell(32'h5566_7788, 8'h60, 1'b0);
        drain();

        mode = 2;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hC0, 1'b1);
        for (int k = 1; k < 20; k++) send_byte(8'(k), 1'b0);
        send_cell(32'hDEAD_BEEF, 8'h30, 1'b0);
        for (int c = 0; c < 6; c++) send_cell(32'($urandom), 8'h00, 1'b1);
        drain();

        mode = 0;
        send_cell(32'h0F1E_2D3C, 8'h00, 1'b1);
        begin
            int t;
            for (t = 0; t < 2000; t++) begin
                if (mon_k == 30) break;
                @(posedge clk); #1;
            end
            check("reach_k30", 32'(mon_k), 32'd30);
        end
        do_reset();
        send_cell(32'h7777_0001, 8'h05, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
